// File: rtl/edge2pulse_pkg.sv
// edge2pulse_pkg: shared types and constants
// for the multi-channel edge-to-pulse array.
package edge2pulse_pkg;

  typedef enum logic [1:0] {
    EDGE_RISING,
    EDGE_FALLING,
    EDGE_BOTH
  } edge_mode_e;

  localparam int MAX_PULSE_W = 15;
  localparam int CNT_W       = 4;

  function automatic logic [31:0] spike_inf(
    input int tw
  );
    return (32'd1 << tw) - 32'd1;
  endfunction

endpackage

// File: rtl/edge2pulse_chan.sv
// edge2pulse_chan: one channel -- edge detect,
// pulse stretcher, one-shot gate, first-edge time latch.
module edge2pulse_chan
  import edge2pulse_pkg::*;
#(
  parameter edge_mode_e MODE     = EDGE_RISING,
  parameter int         PULSE_W  = 1,
  parameter bit         ONE_SHOT = 1'b1,
  parameter int         TW       = 4
) (
  input  logic          aclk,
  input  logic          grst,
  input  logic          edge_input,
  input  logic [TW-1:0] time_cnt,
  output logic          pulse_output,
  output logic          fired,
  output logic [TW-1:0] spike_time
);

  localparam logic [TW-1:0]    INF = TW'(spike_inf(TW));
  localparam logic [CNT_W-1:0] PW  = CNT_W'(PULSE_W);

  logic             prev_q;
  logic [CNT_W-1:0] cnt;
  logic             rise;
  logic             fall;
  logic             qual;
  logic             hit;

  // Classify the transition and decide whether it fires.
  always_comb begin
    rise = edge_input & ~prev_q;
    fall = ~edge_input & prev_q;
    qual = 1'b0;
    unique case (MODE)
      EDGE_RISING:  qual = rise;
      EDGE_FALLING: qual = fall;
      EDGE_BOTH:    qual = rise | fall;
      default:      qual = 1'b0;
    endcase
    hit = qual;
    if (ONE_SHOT && (fired || cnt != '0))
      hit = 1'b0;
  end

  // Edge history, pulse counter and first-edge latch.
  always_ff @(posedge aclk) begin
    if (grst) begin
      prev_q     <= edge_input;
      cnt        <= '0;
      fired      <= 1'b0;
      spike_time <= INF;
    end else begin
      prev_q <= edge_input;
      if (hit)
        cnt <= PW;
      else if (cnt != '0)
        cnt <= cnt - 1'b1;
      if (qual && !fired) begin
        fired      <= 1'b1;
        spike_time <= time_cnt;
      end
    end
  end

  assign pulse_output = (cnt != '0);

endmodule

// File: rtl/edge2pulse_array.sv
// edge2pulse_array: N_CH edge-to-pulse channels
// sharing one saturating gamma-window time counter.
module edge2pulse_array
  import edge2pulse_pkg::*;
#(
  parameter int         N_CH     = 8,
  parameter edge_mode_e MODE     = EDGE_RISING,
  parameter int         PULSE_W  = 1,
  parameter bit         ONE_SHOT = 1'b1,
  parameter int         TW       = 4
) (
  input  logic                     aclk,
  input  logic                     grst,
  input  logic [N_CH-1:0]          edge_input,
  output logic [N_CH-1:0]          pulse_output,
  output logic [N_CH-1:0]          fired,
  output logic [N_CH-1:0][TW-1:0]  spike_time
);

  localparam logic [TW-1:0] INF = TW'(spike_inf(TW));

  logic [TW-1:0] time_cnt;

  // Window clock: cycles since grst, saturating at INF.
  always_ff @(posedge aclk) begin
    if (grst)
      time_cnt <= '0;
    else if (time_cnt != INF)
      time_cnt <= time_cnt + 1'b1;
  end

  // Parameter range guards.
  always_ff @(posedge aclk) begin
    assert (PULSE_W >= 1 && PULSE_W <= MAX_PULSE_W);
    assert (N_CH >= 1 && TW >= 1 && TW <= 31);
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    edge2pulse_chan #(
      .MODE     (MODE),
      .PULSE_W  (PULSE_W),
      .ONE_SHOT (ONE_SHOT),
      .TW       (TW)
    ) u_chan (
      .aclk         (aclk),
      .grst         (grst),
      .edge_input   (edge_input[i]),
      .time_cnt     (time_cnt),
      .pulse_output (pulse_output[i]),
      .fired        (fired[i]),
      .spike_time   (spike_time[i])
    );
  end

endmodule

// File: tb/tb_edge2pulse_array.sv
// tb_edge2pulse_array: directed checks over six
// configurations of edge2pulse_array.
module tb_edge2pulse_array;
  import edge2pulse_pkg::*;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  int n_pass = 0;
  int n_chk  = 0;

  logic r1, r2, r3, r4, r5, r6;
  logic i1, i2, i3, i4, i5;
  logic [3:0] i6;
  logic p1, p2, p3, p4, p5;
  logic f1, f2, f3, f4, f5;
  logic [0:0][3:0] s1, s2, s3, s4, s5;
  logic [3:0] p6, f6;
  logic [3:0][2:0] s6;

  edge2pulse_array #(
    .N_CH(1), .MODE(EDGE_RISING), .PULSE_W(1),
    .ONE_SHOT(1'b1), .TW(4)
  ) u1 (
    .aclk(aclk), .grst(r1), .edge_input(i1),
    .pulse_output(p1), .fired(f1), .spike_time(s1)
  );

  edge2pulse_array #(
    .N_CH(1), .MODE(EDGE_FALLING), .PULSE_W(1),
    .ONE_SHOT(1'b1), .TW(4)
  ) u2 (
    .aclk(aclk), .grst(r2), .edge_input(i2),
    .pulse_output(p2), .fired(f2), .spike_time(s2)
  );

  edge2pulse_array #(
    .N_CH(1), .MODE(EDGE_RISING), .PULSE_W(3),
    .ONE_SHOT(1'b0), .TW(4)
  ) u3 (
    .aclk(aclk), .grst(r3), .edge_input(i3),
    .pulse_output(p3), .fired(f3), .spike_time(s3)
  );

  edge2pulse_array #(
    .N_CH(1), .MODE(EDGE_BOTH), .PULSE_W(1),
    .ONE_SHOT(1'b1), .TW(4)
  ) u4 (
    .aclk(aclk), .grst(r4), .edge_input(i4),
    .pulse_output(p4), .fired(f4), .spike_time(s4)
  );

  edge2pulse_array #(
    .N_CH(1), .MODE(EDGE_RISING), .PULSE_W(4),
    .ONE_SHOT(1'b1), .TW(4)
  ) u5 (
    .aclk(aclk), .grst(r5), .edge_input(i5),
    .pulse_output(p5), .fired(f5), .spike_time(s5)
  );

  edge2pulse_array #(
    .N_CH(4), .MODE(EDGE_RISING), .PULSE_W(1),
    .ONE_SHOT(1'b1), .TW(3)
  ) u6 (
    .aclk(aclk), .grst(r6), .edge_input(i6),
    .pulse_output(p6), .fired(f6), .spike_time(s6)
  );

  task automatic chk(
    input string tag,
    input int    obs,
    input int    exp
  );
    n_chk++;
    if (obs == exp)
      n_pass++;
    else
      $display("FAIL %s: got %0d expected %0d",
               tag, obs, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  initial begin
    r1 = 1; r2 = 1; r3 = 1; r4 = 1; r5 = 1; r6 = 1;
    i1 = 0; i2 = 1; i3 = 0; i4 = 0; i5 = 0; i6 = '0;
    tick(2);
    chk("rst_pulse", int'(p1), 0);
    chk("rst_fired", int'(f1), 0);
    chk("rst_spike", int'(s1), 15);
    chk("rst_spike6", int'(s6), 12'hfff);

    // T1: rising, cycles 0..2 idle, rise into 3
    r1 = 0;
    tick(3);
    chk("t1_c2_pulse", int'(p1), 0);
    i1 = 1;
    tick();
    chk("t1_c3_pulse", int'(p1), 1);
    chk("t1_c3_spike", int'(s1), 3);
    chk("t1_c3_fired", int'(f1), 1);
    i1 = 0;
    tick();
    chk("t1_c4_pulse", int'(p1), 0);
    tick();
    chk("t1_c5_pulse", int'(p1), 0);
    chk("t1_spike_hold", int'(s1), 3);

    // T2: falling, held high across release
    r2 = 0;
    tick();
    chk("t2_c0_pulse", int'(p2), 0);
    tick(4);
    chk("t2_c4_pulse", int'(p2), 0);
    chk("t2_c4_fired", int'(f2), 0);
    i2 = 0;
    tick();
    chk("t2_c5_pulse", int'(p2), 1);
    chk("t2_c5_spike", int'(s2), 5);
    tick();
    chk("t2_c6_pulse", int'(p2), 0);

    // T3: width 3, retrigger extends
    r3 = 0;
    tick(2);
    i3 = 1;
    tick();
    chk("t3_c2_pulse", int'(p3), 1);
    chk("t3_c2_spike", int'(s3), 2);
    i3 = 0;
    tick();
    chk("t3_c3_pulse", int'(p3), 1);
    i3 = 1;
    tick();
    chk("t3_c4_pulse", int'(p3), 1);
    tick();
    chk("t3_c5_pulse", int'(p3), 1);
    tick();
    chk("t3_c6_pulse", int'(p3), 1);
    tick();
    chk("t3_c7_pulse", int'(p3), 0);
    chk("t3_spike_hold", int'(s3), 2);

    // T4: both edges, one-shot, new window
    r4 = 0;
    tick();
    i4 = 1;
    tick();
    chk("t4_c1_pulse", int'(p4), 1);
    chk("t4_c1_spike", int'(s4), 1);
    tick();
    chk("t4_c2_pulse", int'(p4), 0);
    tick(3);
    i4 = 0;
    tick();
    chk("t4_c6_pulse", int'(p4), 0);
    chk("t4_c6_spike", int'(s4), 1);
    r4 = 1;
    tick();
    chk("t4_rst_spike", int'(s4), 15);
    chk("t4_rst_fired", int'(f4), 0);
    r4 = 0;
    tick(2);
    i4 = 1;
    tick();
    chk("t4_w2_pulse", int'(p4), 1);
    chk("t4_w2_spike", int'(s4), 2);

    // T5: reset cuts a 4-wide pulse
    r5 = 0;
    tick(3);
    i5 = 1;
    tick();
    chk("t5_c3_pulse", int'(p5), 1);
    tick();
    chk("t5_c4_pulse", int'(p5), 1);
    r5 = 1;
    tick();
    chk("t5_rst_pulse", int'(p5), 0);
    chk("t5_rst_fired", int'(f5), 0);
    chk("t5_rst_spike", int'(s5), 15);
    r5 = 0;
    tick(2);
    chk("t5_held_pulse", int'(p5), 0);
    chk("t5_held_fired", int'(f5), 0);

    // T6: four channels, TW=3 saturation
    i6 = 4'b0001;
    r6 = 0;
    tick();
    chk("t6_c0_pulse", int'(p6), 4'b0001);
    chk("t6_c0_spike0", int'(s6[0]), 0);
    tick(5);
    chk("t6_c5_pulse", int'(p6), 0);
    i6 = 4'b0011;
    tick();
    chk("t6_c6_pulse", int'(p6), 4'b0010);
    tick(2);
    i6 = 4'b0111;
    tick();
    chk("t6_c9_pulse", int'(p6), 4'b0100);
    chk("t6_spike", int'(s6), 12'hff0);
    chk("t6_fired", int'(f6), 4'b0111);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/edge2pulse_array.md
Name: edge2pulse_array

Overview:
- Multi-channel, parametrised successor to the single-channel edge-to-pulse converter.
- Each channel watches a level/edge input and emits a programmable-width pulse on the selected transition(s).
- Each channel optionally limits itself to one pulse per gamma window, where `grst` opens a new window.
- Each channel records the arrival time of its first edge, in aclk cycles since window start; this feeds temporal (race-logic) columns that consume spike times.

Parameters:
- N_CH, 8, number of independent channels.
- MODE, EDGE_RISING, edge select from `edge_mode_e`: EDGE_RISING, EDGE_FALLING or EDGE_BOTH.
- PULSE_W, 1, pulse length in aclk cycles; range 1..15.
- ONE_SHOT, 1, 1 = at most one pulse per channel per window; 0 = every qualifying edge pulses.
- TW, 4, spike-time width; all-ones (2^TW-1) encodes "no spike / infinity".

Ports:
- aclk  input  1  sole clock; all state updates on posedge.
- grst  input  1  synchronous, active-high reset; also marks the start of a gamma window.
- edge_input  input  N_CH  per-channel input, already synchronous to aclk.
- pulse_output  output  N_CH  per-channel pulse.
- fired  output  N_CH  channel has latched a first edge this window.
- spike_time  output  [N_CH-1:0][TW-1:0]  first-edge time per channel.

Behaviour:
- Reset: one clock, aclk. Reset is synchronous and active-high; at any posedge with grst=1:
  - pulse_output=0, fired=0, spike_time=all-ones, pulse counters=0, time_cnt=0.
  - prev_q loads the current edge_input, so an input already at its active level at reset release produces no pulse.
- Edge detect at posedge t, grst=0:
  - rise = edge_input & ~prev_q; fall = ~edge_input & prev_q.
  - qualify = rise, fall, or rise|fall, per MODE.
  - prev_q <= edge_input every cycle.
- Latency: an input change made between posedge t-1 and t gives pulse_output=1 immediately after posedge t. That is one cycle of latency, fully registered, with no combinational input-to-output path.
- Pulse width: on a qualifying edge, cnt <= PULSE_W. pulse_output = (cnt != 0). cnt decrements each cycle while nonzero, so the output is high for exactly PULSE_W cycles.
- Retrigger during an active pulse:
  - ONE_SHOT=0: cnt reloads to PULSE_W, extending the pulse; there is no gap.
  - ONE_SHOT=1: the edge is ignored.
- ONE_SHOT gating: a qualifying edge while fired=1 is ignored, with no pulse and no time update, until the next grst.
- Time counter (shared by all channels):
  - time_cnt increments each non-reset cycle and saturates at 2^TW-1.
  - The first non-reset posedge sees time_cnt=0.
- Spike time: on a channel's first qualifying edge in the window (fired=0), spike_time <= time_cnt (value before increment) and fired <= 1.
  - Later edges never change spike_time, even when ONE_SHOT=0.
  - An edge with time_cnt saturated latches all-ones with fired=1; the pulse is still emitted.
- Simultaneous events:
  - grst and an edge in the same cycle: reset wins, and no pulse results.
  - Edges on multiple channels in one cycle are handled independently.
- Reset mid-pulse: pulse_output drops to 0 after the reset posedge and the counter is cleared; no residual pulse.
- Input held at the active level: produces no further pulses, because detection is edge-based only.

Decomposition:
- Package `edge2pulse_pkg`:
  - typedef enum `edge_mode_e` {EDGE_RISING, EDGE_FALLING, EDGE_BOTH};
  - constant MAX_PULSE_W=15;
  - function `spike_inf(TW)` returning all-ones.
- Sub-module `edge2pulse_chan`: one channel, holding prev_q, the pulse counter, fired and the spike-time latch. It takes time_cnt as an input.
- The top level holds only the shared time_cnt, a generate loop over N_CH channel instances, and parameter range assertions.

Test Plan:
1. N_CH=1, MODE=RISING, PULSE_W=1:
   - Stimulus: grst for 2 cycles with input=0, release, input 0→1 at cycle 3, back to 0 at cycle 4.
   - Required: pulse_output=1 only in cycle 3 (one cycle); spike_time=3; fired=1.
2. MODE=FALLING:
   - Stimulus: input=1 through reset release, then 1→0 at cycle 5.
   - Required: no pulse at release; pulse in cycle 5 only; spike_time=5.
3. PULSE_W=3, ONE_SHOT=0, MODE=RISING:
   - Stimulus: rise at cycle 2, fall at cycle 3, rise at cycle 4.
   - Required: pulse high cycles 2–6 (reloaded at 4); spike_time stays 2.
4. ONE_SHOT=1, MODE=BOTH:
   - Stimulus: rise at cycle 1, fall at cycle 6, then grst, then rise at cycle 2 of the new window.
   - Required: a single pulse in cycle 1; none at cycle 6; after grst, spike_time resets to 15, a pulse occurs at cycle 2, and spike_time=2.
5. PULSE_W=4:
   - Stimulus: edge at cycle 3, grst asserted at cycle 5.
   - Required: pulse high cycles 3–4 only, 0 from cycle 5; fired=0; spike_time=15.
6. N_CH=4, TW=3:
   - Stimulus: ch0 rises at cycle 0, ch1 at cycle 6, ch2 at cycle 9, ch3 never.
   - Required: spike_time = {7(ch3), 7(ch2), 6(ch1), 0(ch0)}; fired = 4'b0111; pulses on ch0–2 at their edge cycles.
